// File: rtl/a_igual_b_scanner.sv
// a_igual_b_scanner
// -----------------------------------------------------------------------------
// Search sequencer placed in front of a registered equality comparator
// (a_igual_b). It keeps a small operand table. On start it presents the
// latched key and each table entry to the comparator, one entry at a time,
// and reports the lowest index whose registered comparator result was 1.
//
// Ports
//   clk_i          single clock, rising-edge
//   reset_i        synchronous active-high reset (also clears the table)
//   wr_en_i        table write strobe (ignored while busy)
//   wr_addr_i      table write address
//   wr_data_i      table write data
//   start_i        begin a search (accepted only in IDLE)
//   key_i          search key, latched when start is accepted
//   cmp_a_o        comparator operand A (latched key)
//   cmp_b_o        comparator operand B (table entry under test)
//   cmp_enable_o   comparator enable, high in ISSUE
//   cmp_result_i   registered equality flag from the comparator
//   busy_o         search in progress
//   done_o         one-cycle completion pulse
//   found_o        search hit flag, held until the next accepted start
//   match_idx_o    lowest matching index, 0 when nothing matched
// -----------------------------------------------------------------------------
module a_igual_b_scanner #(
  parameter int INPUTSIZE = 8,
  parameter int DEPTH     = 8,
  parameter int IDXSIZE   = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_en_i,
  input  logic [IDXSIZE-1:0]   wr_addr_i,
  input  logic [INPUTSIZE-1:0] wr_data_i,
  input  logic                 start_i,
  input  logic [INPUTSIZE-1:0] key_i,
  output logic [INPUTSIZE-1:0] cmp_a_o,
  output logic [INPUTSIZE-1:0] cmp_b_o,
  output logic                 cmp_enable_o,
  input  logic                 cmp_result_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 found_o,
  output logic [IDXSIZE-1:0]   match_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [IDXSIZE-1:0] LAST_IDX = IDXSIZE'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [INPUTSIZE-1:0]   key_q, key_d;
  logic [IDXSIZE-1:0]     idx_q, idx_d;
  logic                   found_q, found_d;
  logic [IDXSIZE-1:0]     match_idx_q, match_idx_d;
  logic [INPUTSIZE-1:0]   table_q [DEPTH];

  // Operand table: writes only land while idle, so a search sees a frozen table.
  // A write in the same cycle as an accepted start commits on that edge and is
  // therefore visible to the first ISSUE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_en_i && (state_q == S_IDLE)) begin
      table_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Sequencer state and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      match_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      match_idx_q <= match_idx_d;
    end
  end

  // Next-state logic. cmp_result_i is looked at only in WAIT: the comparator
  // registers its answer on the edge that ends ISSUE, and outside WAIT it may
  // be undefined.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    idx_d       = idx_q;
    found_d     = found_q;
    match_idx_d = match_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d       = key_i;
          idx_d       = '0;
          found_d     = 1'b0;
          match_idx_d = '0;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cmp_result_i == 1'b1) begin
          found_d     = 1'b1;
          match_idx_d = idx_q;
          state_d     = S_DONE;
        end else if (idx_q == LAST_IDX) begin
          found_d     = 1'b0;
          match_idx_d = '0;
          state_d     = S_DONE;
        end else begin
          idx_d   = idx_q + IDXSIZE'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode from registers only.
  assign cmp_a_o      = key_q;
  assign cmp_b_o      = table_q[idx_q];
  assign cmp_enable_o = (state_q == S_ISSUE);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign found_o      = found_q;
  assign match_idx_o  = match_idx_q;

endmodule

// File: doc/a_igual_b_scanner.md
# a_igual_b_scanner

Sequencer that drives an external registered equality comparator from the issuing side. It holds a small table of operands and, on `start`, presents the search key and each table entry to the comparator in turn. It samples the comparator's registered result one cycle after each issue and reports the lowest matching index. It sits in the processor datapath as the initiator in front of the `a_igual_b` comparator, whose `ab_out` it consumes.

## Interface
- `inputsize`, 8, operand width in bits.
- `depth`, 8, number of table entries; ≥2.
- `idxsize`, 3, index width; must equal clog2(`depth`).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  idxsize  table write address.
- `wr_data`  in  inputsize  table write data.
- `start`  in  1  begin a search; accepted only in IDLE.
- `key`  in  inputsize  search key; latched when `start` is accepted.
- `cmp_a`  out  inputsize  comparator operand A; connects to comparator `A`.
- `cmp_b`  out  inputsize  comparator operand B; connects to comparator `B`.
- `cmp_enable`  out  1  comparator enable; connects to comparator `enable`.
- `cmp_result`  in  1  registered equality flag from the comparator (`ab_out`).
- `busy`  out  1  high while a search is in progress.
- `done`  out  1  one-cycle pulse when a search completes.
- `found`  out  1  search result; holds until the next accepted `start`.
- `match_idx`  out  idxsize  lowest matching index; 0 when `found`=0.

## Operation
- Table: `depth` × `inputsize` registers, all cleared to 0 on `reset`.
  - A write occurs when `wr_en`=1 and `busy`=0.
  - Writes are ignored while `busy`=1.
- Registers: `key_q`, `idx`.
  - `cmp_a`=`key_q`, `cmp_b`=table[`idx`] at all times.
  - These outputs decode only from registers; there is no combinational input-to-output path.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: `busy`=0. When `start`=1, latch `key`, set `idx`=0, clear `found` and `match_idx`, go to ISSUE.
  - ISSUE: `cmp_enable`=1. Go to WAIT.
  - WAIT: `cmp_enable`=0. Sample `cmp_result`.
    - If 1: `found`←1, `match_idx`←`idx`, go to DONE.
    - Else if `idx`=`depth`-1: `found`←0, `match_idx`←0, go to DONE.
    - Else: `idx`←`idx`+1, go to ISSUE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `busy`=1 in ISSUE, WAIT and DONE. `start` is ignored whenever `busy`=1.
- `cmp_result` is sampled only in WAIT. Its value in every other cycle, including X/Z driven by the comparator after its own reset, is ignored.
- `start` and `wr_en` in the same IDLE cycle: the write commits at that edge, and the search sees the new value.
- Duplicate matches: the lowest index wins, because the scan stops at the first hit.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `found` = 0; `match_idx`=0; `cmp_enable`=0; `key_q`=0; `idx`=0.
  - Consequently `cmp_a`=0 and `cmp_b`=0 after reset.
- Reset mid-search aborts the search: the block returns to the reset state at the next edge, and no `done` pulse is generated.
- Comparator contract: the result is registered on the edge that ends the ISSUE cycle and is valid during the following WAIT cycle, i.e. one-cycle latency.
- Each table entry costs 2 cycles (ISSUE + WAIT).
- Latency, with `start` accepted at edge 0:
  - Match at index k: `done` is high in cycle 2k+3.
  - No match: `done` is high in cycle 2·`depth`+1 (17 at `depth`=8).
- `found` and `match_idx` update on the edge entering DONE. They are therefore valid together with `done` and remain stable until the next accepted `start`.
- Earliest next `start`: the cycle after DONE, in IDLE.

## Test plan
Bench uses a behavioural `a_igual_b` (1-cycle registered comparator) on the `cmp_*` ports.
- Reset; load table[i]=8'h10+i for i=0..7; `key`=8'h13; `start` → `done` in cycle 9, `found`=1, `match_idx`=3, exactly 4 `cmp_enable` pulses.
- Same table, `key`=8'hFF → `done` in cycle 17, `found`=0, `match_idx`=0, exactly 8 `cmp_enable` pulses.
- table[2]=table[5]=8'hAA, `key`=8'hAA → `match_idx`=2, `done` in cycle 7.
- Same-cycle write and start: `wr_en` with table[0]←8'h5C together with `start`, `key`=8'h5C → `found`=1, `match_idx`=0, `done` in cycle 3.
  - A `wr_en` and a second `start` issued during `busy` leave the table and the result unchanged.
- Assert `reset` during a WAIT cycle → next cycle all outputs at reset values, no `done`.
  - A following search still works.
  - A comparator stub driving X on `cmp_result` outside WAIT does not affect `found`.
